// File: rtl/axi_ram_responder_pkg.sv
// axi_ram_responder_pkg
//   Shared types and constants for the AXI RAM responder: the FSM state
//   enum, the AXI encodings the responder recognises, and the helper that
//   decides whether an address phase is one this responder can serve.
package axi_ram_responder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    WRESP = 2'd2,
    RDATA = 2'd3
  } state_t;

  localparam logic [2:0] AXSIZE_16B  = 3'h4;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Only 16-byte INCR bursts up to max_len+1 beats are served cleanly.
  // Anything else is still walked beat by beat but answered with SLVERR.
  function automatic logic addr_phase_error(input logic [2:0] size,
                                            input logic [1:0] burst,
                                            input logic [7:0] len,
                                            input logic [7:0] max_len);
    return (size != AXSIZE_16B) || (burst != BURST_INCR) || (len > max_len);
  endfunction

endpackage

// File: rtl/axi_ram_responder.sv
// axi_ram_responder
//   AXI4 slave that serves 128-bit INCR read and write bursts from one port
//   of a local true-dual-port RAM, one transaction at a time.
//
// Ports
//   clock, resetn            sole clock; synchronous active-low reset
//   aw*                      write address channel (id, addr, len, size, burst)
//   w*                       write data channel (data, strb, last)
//   b*                       write response channel (id, resp)
//   ar*                      read address channel (id, addr, len, size, burst)
//   r*                       read data channel (id, data, resp, last)
//   ram_en/we/addr/din/dout  RAM port, 1-cycle read latency, dout held
//                            while en is low
module axi_ram_responder
  import axi_ram_responder_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 8,
  parameter int MAX_LEN        = 15,
  parameter int ID_WIDTH       = 4
) (
  input  logic                      clock,
  input  logic                      resetn,

  input  logic [ID_WIDTH-1:0]       awid,
  input  logic [39:0]               awaddr,
  input  logic [7:0]                awlen,
  input  logic [2:0]                awsize,
  input  logic [1:0]                awburst,
  input  logic                      awvalid,
  output logic                      awready,

  input  logic [127:0]              wdata,
  input  logic [15:0]               wstrb,
  input  logic                      wlast,
  input  logic                      wvalid,
  output logic                      wready,

  output logic [ID_WIDTH-1:0]       bid,
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready,

  input  logic [ID_WIDTH-1:0]       arid,
  input  logic [39:0]               araddr,
  input  logic [7:0]                arlen,
  input  logic [2:0]                arsize,
  input  logic [1:0]                arburst,
  input  logic                      arvalid,
  output logic                      arready,

  output logic [ID_WIDTH-1:0]       rid,
  output logic [127:0]              rdata,
  output logic [1:0]                rresp,
  output logic                      rlast,
  output logic                      rvalid,
  input  logic                      rready,

  output logic                      ram_en,
  output logic [15:0]               ram_we,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic [127:0]              ram_din,
  input  logic [127:0]              ram_dout
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t                    state_q, state_d;
  logic                      armed_q;
  logic                      rr_read_q;
  logic [ID_WIDTH-1:0]       id_q;
  logic [7:0]                len_q;
  logic [7:0]                beat_q;
  logic                      err_q;
  logic [RAM_ADDR_WIDTH-1:0] addr_q;
  logic [RAM_ADDR_WIDTH-1:0] wr_addr_q;
  logic                      wr_en_q;
  logic [15:0]               wr_we_q;
  logic [127:0]              wr_din_q;
  logic                      rd_first_q;
  logic                      rvalid_q;

  logic aw_hs, ar_hs, w_hs, b_hs, r_hs;
  logic rd_fetch;
  logic last_beat;
  logic beat_bad;

  // Byte offset and the address bits above the RAM depth play no part.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{awaddr[39:RAM_ADDR_WIDTH+4], awaddr[3:0],
                              araddr[39:RAM_ADDR_WIDTH+4], araddr[3:0]};

  assign aw_hs = awvalid && awready;
  assign ar_hs = arvalid && arready;
  assign w_hs  = wvalid && wready;
  assign b_hs  = bvalid && bready;
  assign r_hs  = rvalid && rready;

  assign last_beat = (beat_q == len_q);
  // wlast must coincide with the beat counter reaching the captured length;
  // any disagreement (early or late) marks the burst as errored.
  assign beat_bad  = (wlast != last_beat);

  // State register plus all datapath registers. armed_q holds the IDLE
  // readies low for the first cycle after reset is released.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= IDLE;
      armed_q    <= 1'b0;
      rr_read_q  <= 1'b0;
      id_q       <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wr_addr_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_we_q    <= '0;
      wr_din_q   <= '0;
      rd_first_q <= 1'b0;
      rvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      armed_q    <= 1'b1;
      rd_first_q <= ar_hs;
      wr_en_q    <= w_hs;
      wr_we_q    <= (w_hs && !err_q && !beat_bad) ? wstrb : '0;

      if (aw_hs || ar_hs) begin
        rr_read_q <= !rr_read_q;
      end

      if (aw_hs) begin
        id_q   <= awid;
        len_q  <= awlen;
        beat_q <= '0;
        err_q  <= addr_phase_error(awsize, awburst, awlen, MAX_LEN_B);
        addr_q <= awaddr[RAM_ADDR_WIDTH+3:4];
      end else if (ar_hs) begin
        id_q   <= arid;
        len_q  <= arlen;
        beat_q <= '0;
        err_q  <= addr_phase_error(arsize, arburst, arlen, MAX_LEN_B);
        addr_q <= araddr[RAM_ADDR_WIDTH+3:4];
      end

      if (w_hs) begin
        wr_addr_q <= addr_q;
        wr_din_q  <= wdata;
        addr_q    <= addr_q + RAM_ADDR_WIDTH'(1);
        beat_q    <= beat_q + 8'd1;
        if (beat_bad) begin
          err_q <= 1'b1;
        end
      end

      // On reads addr_q always points at the next word to fetch.
      if (rd_fetch) begin
        addr_q <= addr_q + RAM_ADDR_WIDTH'(1);
      end

      if (rd_fetch) begin
        rvalid_q <= 1'b1;
      end else if (r_hs) begin
        rvalid_q <= 1'b0;
      end

      if (r_hs) begin
        beat_q <= beat_q + 8'd1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (aw_hs) begin
          state_d = WDATA;
        end else if (ar_hs) begin
          state_d = RDATA;
        end
      end
      WDATA: begin
        if (w_hs && wlast) begin
          state_d = WRESP;
        end
      end
      WRESP: begin
        if (b_hs) begin
          state_d = IDLE;
        end
      end
      RDATA: begin
        if (r_hs && rlast) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic. In IDLE both readies come from registers; the only
  // combinational term is the contest mask, which drops the loser's ready
  // when both address channels are valid so exactly one handshake occurs.
  // Read fetches happen once after the AR handshake and then on every
  // non-last R handshake, so a held rready gives one beat per cycle and a
  // stalled beat never disturbs dout.
  always_comb begin
    awready  = 1'b0;
    arready  = 1'b0;
    wready   = 1'b0;
    bvalid   = 1'b0;
    bresp    = RESP_OKAY;
    rvalid   = 1'b0;
    rresp    = RESP_OKAY;
    rlast    = 1'b0;
    rd_fetch = 1'b0;
    case (state_q)
      IDLE: begin
        if (armed_q) begin
          awready = !(arvalid && rr_read_q);
          arready = !(awvalid && !rr_read_q);
        end
      end
      WDATA: begin
        wready = 1'b1;
      end
      WRESP: begin
        bvalid = 1'b1;
        bresp  = err_q ? RESP_SLVERR : RESP_OKAY;
      end
      RDATA: begin
        rvalid = rvalid_q;
        if (rvalid_q) begin
          rlast = last_beat;
          rresp = err_q ? RESP_SLVERR : RESP_OKAY;
        end
        rd_fetch = rd_first_q || (rvalid_q && rready && !last_beat);
      end
      default: begin
      end
    endcase
  end

  assign bid      = id_q;
  assign rid      = id_q;
  assign rdata    = ram_dout;
  assign ram_en   = wr_en_q || rd_fetch;
  assign ram_we   = wr_we_q;
  assign ram_addr = (state_q == RDATA) ? addr_q : wr_addr_q;
  assign ram_din  = wr_din_q;

endmodule

// File: tb/tb_axi_ram_responder.sv
// tb_axi_ram_responder
//   Directed bench for axi_ram_responder: drives the AXI channels from one
//   initial block, models the RAM port behind the responder, and checks
//   responses, RAM contents and cycle timing against hand-computed values.
module tb_axi_ram_responder;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] INCR   = 2'b01;

  logic         clock;
  logic         resetn;
  logic [3:0]   awid;
  logic [39:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         awvalid;
  logic         awready;
  logic [127:0] wdata;
  logic [15:0]  wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;
  logic [3:0]   bid;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic [3:0]   arid;
  logic [39:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready;
  logic [3:0]   rid;
  logic [127:0] rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;
  logic         ram_en;
  logic [15:0]  ram_we;
  logic [7:0]   ram_addr;
  logic [127:0] ram_din;
  logic [127:0] ram_dout;

  int checks = 0;
  int errors = 0;
  logic [127:0] expWords [0:15];
  logic [127:0] mem [0:255];
  logic         tb_load;
  logic [1:0]   resp;

  axi_ram_responder #(.RAM_ADDR_WIDTH(8), .MAX_LEN(15), .ID_WIDTH(4)) dut (
    .clock(clock), .resetn(resetn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [127:0] initWord(input int i);
    return {4{32'hC0DE_0000 | 32'(i)}};
  endfunction

  // RAM port model: byte-enabled write, read-first, 1-cycle latency,
  // dout held while en is low.
  always @(posedge clock) begin
    if (tb_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= initWord(i);
    end else if (ram_en) begin
      for (int b = 0; b < 16; b++) begin
        if (ram_we[b]) mem[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
      end
      ram_dout <= mem[ram_addr];
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs,
                             input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(negedge clock);
  endtask

  task automatic writeBurst(input logic [3:0] id, input logic [39:0] addr,
                            input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [127:0] base,
                            input logic [15:0] strb, input int last_beat,
                            output logic [1:0] wresp);
    int t;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
    awvalid = 1'b1;
    t = 0; #1;
    while (!awready && t < 20) begin applyStimulus(1); #1; t++; end
    checkOutput("wr_aw_accept", awready, 1'b1);
    applyStimulus(1);
    awvalid = 1'b0;
    for (int b = 0; b <= last_beat; b++) begin
      wdata = base + 128'(b); wstrb = strb; wlast = (b == last_beat); wvalid = 1'b1;
      t = 0; #1;
      while (!wready && t < 20) begin applyStimulus(1); #1; t++; end
      checkOutput("wr_w_accept", wready, 1'b1);
      applyStimulus(1);
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    t = 0; #1;
    while (!bvalid && t < 20) begin applyStimulus(1); #1; t++; end
    checkOutput("wr_bvalid", bvalid, 1'b1);
    checkOutput("wr_bid", bid, id);
    wresp = bresp;
    applyStimulus(1);
    bready = 1'b0;
  endtask

  // rr_pat bit (cycle % 4) is rready for that cycle, counted from the first
  // cycle in which rvalid is due (AR handshake + 2).
  task automatic readBurst(input string tag, input logic [39:0] addr,
                           input logic [7:0] len, input logic [1:0] burst,
                           input logic [1:0] exp_resp, input logic [3:0] rr_pat);
    int t, beat, cyc;
    logic done;
    arid = 4'h7; araddr = addr; arlen = len; arsize = 3'd4; arburst = burst;
    arvalid = 1'b1;
    t = 0; #1;
    while (!arready && t < 20) begin applyStimulus(1); #1; t++; end
    checkOutput({tag, "_ar_accept"}, arready, 1'b1);
    applyStimulus(1);
    arvalid = 1'b0; #1;
    checkOutput({tag, "_rvalid_n1"}, rvalid, 1'b0);
    checkOutput({tag, "_en_n1"}, ram_en, 1'b1);
    beat = 0; done = 1'b0; cyc = 0;
    while (!done && cyc < 40) begin
      applyStimulus(1);
      rready = rr_pat[cyc % 4]; #1;
      if (cyc == 0) checkOutput({tag, "_rvalid_n2"}, rvalid, 1'b1);
      if (rvalid) begin
        if (beat < 16) checkOutput({tag, "_rdata"}, rdata, expWords[beat]);
        checkOutput({tag, "_rlast"}, rlast, (beat == int'(len)));
        checkOutput({tag, "_rresp"}, rresp, exp_resp);
        checkOutput({tag, "_rid"}, rid, 4'h7);
        if (!rready) checkOutput({tag, "_stall_en"}, ram_en, 1'b0);
        if (rready) begin
          if (beat == int'(len)) done = 1'b1;
          beat++;
        end
      end
      cyc++;
    end
    checkOutput({tag, "_complete"}, done, 1'b1);
    applyStimulus(1);
    rready = 1'b0; #1;
    checkOutput({tag, "_rvalid_after"}, rvalid, 1'b0);
  endtask

  initial begin
    tb_load = 1'b1; resetn = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = 3'd4; awburst = INCR; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = 3'd4; arburst = INCR; arvalid = 1'b0;
    rready = 1'b0;
    $display("[TB] start");
    applyStimulus(3);
    tb_load = 1'b0; #1;
    checkOutput("rst_awready", awready, 1'b0);
    checkOutput("rst_arready", arready, 1'b0);
    checkOutput("rst_wready", wready, 1'b0);
    checkOutput("rst_bvalid", bvalid, 1'b0);
    checkOutput("rst_rvalid", rvalid, 1'b0);
    checkOutput("rst_rlast", rlast, 1'b0);
    checkOutput("rst_en", ram_en, 1'b0);
    checkOutput("rst_we", ram_we, 16'h0);
    checkOutput("rst_bresp", bresp, 2'b00);
    checkOutput("rst_rresp", rresp, 2'b00);
    resetn = 1'b1;
    checkOutput("rst_release_awready", awready, 1'b0);

    // Contest 1 straight after reset: write wins.
    applyStimulus(1);
    awid = 4'h3; awaddr = 40'h40; awlen = 8'd0; awsize = 3'd4; awburst = INCR; awvalid = 1'b1;
    arid = 4'h5; araddr = 40'h80; arlen = 8'd0; arsize = 3'd4; arburst = INCR; arvalid = 1'b1;
    #1;
    checkOutput("c1_awready", awready, 1'b1);
    checkOutput("c1_arready_lose", arready, 1'b0);
    applyStimulus(1);
    awvalid = 1'b0;
    wdata = 128'h1111_2222_3333_4444_5555_6666_7777_8888; wstrb = 16'hFFFF;
    wlast = 1'b1; wvalid = 1'b1; #1;
    checkOutput("c1_wready", wready, 1'b1);
    checkOutput("c1_arready_busy", arready, 1'b0);
    applyStimulus(1);
    wvalid = 1'b0; wlast = 1'b0; #1;
    checkOutput("c1_bvalid", bvalid, 1'b1);
    checkOutput("c1_bresp", bresp, OKAY);
    checkOutput("c1_bid", bid, 4'h3);
    checkOutput("c1_ram_en", ram_en, 1'b1);
    checkOutput("c1_ram_we", ram_we, 16'hFFFF);
    checkOutput("c1_ram_addr", ram_addr, 8'd4);
    applyStimulus(1);
    bready = 1'b1; #1;
    checkOutput("c1_bvalid_hold", bvalid, 1'b1);

    // Contest 2: read wins.
    applyStimulus(1);
    bready = 1'b0;
    awid = 4'h6; awaddr = 40'h40; awvalid = 1'b1; #1;
    checkOutput("c2_arready", arready, 1'b1);
    checkOutput("c2_awready_lose", awready, 1'b0);
    applyStimulus(1);
    arvalid = 1'b0; #1;
    checkOutput("c2_rvalid_n1", rvalid, 1'b0);
    checkOutput("c2_en_n1", ram_en, 1'b1);
    checkOutput("c2_addr_n1", ram_addr, 8'd8);
    applyStimulus(1);
    rready = 1'b1; #1;
    checkOutput("c2_rvalid_n2", rvalid, 1'b1);
    checkOutput("c2_rdata", rdata, initWord(8));
    checkOutput("c2_rlast", rlast, 1'b1);
    checkOutput("c2_rid", rid, 4'h5);
    applyStimulus(1);
    rready = 1'b0;
    writeBurst(4'h6, 40'h40, 8'd0, 3'd4, INCR,
               128'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000_9999, 16'h000F, 0, resp);
    checkOutput("strb_bresp", resp, OKAY);
    checkOutput("strb_mem4", mem[4], 128'h1111_2222_3333_4444_5555_6666_0000_9999);

    // 4-beat read, rready held high, then the same read under backpressure.
    expWords[0] = 128'h1111_2222_3333_4444_5555_6666_0000_9999;
    expWords[1] = initWord(5);
    expWords[2] = initWord(6);
    expWords[3] = initWord(7);
    readBurst("rd4", 40'h40, 8'd3, INCR, OKAY, 4'b1111);
    readBurst("rdbp", 40'h40, 8'd3, INCR, OKAY, 4'b1001);

    // Error cases.
    writeBurst(4'h1, 40'h100, 8'd0, 3'd3, INCR, 128'hDEAD, 16'hFFFF, 0, resp);
    checkOutput("err_size_bresp", resp, SLVERR);
    checkOutput("err_size_mem", mem[16], initWord(16));
    writeBurst(4'h2, 40'h200, 8'd3, 3'd4, INCR, 128'hBEEF, 16'hFFFF, 1, resp);
    checkOutput("err_early_wlast_bresp", resp, SLVERR);
    writeBurst(4'h4, 40'h500, 8'd16, 3'd4, INCR, 128'hF00D, 16'hFFFF, 16, resp);
    checkOutput("err_len_bresp", resp, SLVERR);
    checkOutput("err_len_mem", mem[80], initWord(80));
    expWords[0] = initWord(8);
    readBurst("rderr", 40'h80, 8'd0, 2'b10, SLVERR, 4'b1111);

    // Wrap past the top word; upper address bits and byte offset ignored.
    writeBurst(4'h9, 40'hF0_0000_0FF5, 8'd3, 3'd4, INCR,
               128'h5000_0000_0000_0000_0000_0000_0000_0000, 16'hFFFF, 3, resp);
    checkOutput("wrap_bresp", resp, OKAY);
    checkOutput("wrap_mem255", mem[255], 128'h5000_0000_0000_0000_0000_0000_0000_0000);
    checkOutput("wrap_mem0", mem[0], 128'h5000_0000_0000_0000_0000_0000_0000_0001);
    checkOutput("wrap_mem2", mem[2], 128'h5000_0000_0000_0000_0000_0000_0000_0003);
    checkOutput("wrap_mem3", mem[3], initWord(3));
    for (int i = 0; i < 4; i++) expWords[i] = 128'h5000_0000_0000_0000_0000_0000_0000_0000 + 128'(i);
    readBurst("rdwrap", 40'hFF0, 8'd3, INCR, OKAY, 4'b1111);

    // Reset in the middle of a read burst.
    arid = 4'h7; araddr = 40'h40; arlen = 8'd3; arsize = 3'd4; arburst = INCR; arvalid = 1'b1;
    #1;
    checkOutput("mr_arready", arready, 1'b1);
    applyStimulus(1);
    arvalid = 1'b0;
    applyStimulus(1);
    #1;
    checkOutput("mr_rvalid_before", rvalid, 1'b1);
    resetn = 1'b0;
    applyStimulus(1);
    #1;
    checkOutput("mr_rvalid", rvalid, 1'b0);
    checkOutput("mr_awready", awready, 1'b0);
    checkOutput("mr_arready_low", arready, 1'b0);
    checkOutput("mr_wready", wready, 1'b0);
    checkOutput("mr_bvalid", bvalid, 1'b0);
    checkOutput("mr_en", ram_en, 1'b0);
    resetn = 1'b1;
    applyStimulus(1);
    #1;
    checkOutput("mr_awready_back", awready, 1'b1);
    writeBurst(4'hA, 40'h300, 8'd0, 3'd4, INCR, 128'h0123_4567_89AB_CDEF, 16'hFFFF, 0, resp);
    checkOutput("mr_w_bresp", resp, OKAY);
    checkOutput("mr_mem48", mem[48], 128'h0123_4567_89AB_CDEF);
    expWords[0] = 128'h0123_4567_89AB_CDEF;
    readBurst("mr_rd", 40'h300, 8'd0, INCR, OKAY, 4'b1111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
